// File: rtl/sid_pkg.sv
// sid_pkg: shared definitions for the time-multiplexed SID filter.
//   sid_filt_state_t : sequencer states, one per clock of a sample computation
//   FC_OFFSET .. FC_SHIFT : cutoff/resonance mapping and product scaling
//   sat()            : symmetric clamp of a 64-bit value to a given width
package sid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        HIGH,
        BAND,
        LOW,
        MIX,
        OUT
    } sid_filt_state_t;

    localparam int FC_OFFSET = 64;
    localparam int RES_BASE  = 256;
    localparam int RES_STEP  = 10;
    localparam int RES_SHIFT = 8;
    localparam int FC_SHIFT  = 16;

    // Clamp to +/-(2^(w-1)-1). The negative limit is symmetric so that a
    // negated state never overflows.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (x > lim) begin
            return lim;
        end else if (x < -lim) begin
            return -lim;
        end
        return x;
    endfunction

endpackage

// File: rtl/sid_sat_mac.sv
// sid_sat_mac: single shared multiplier of the filter.
//   y = sat(acc +/- ((a * b) >>> SHIFT)), purely combinational.
// Ports:
//   acc          in  ACC_W+1 signed  accumulator term (one extra bit so the
//                                    high-pass input difference cannot wrap)
//   a, b         in  ACC_W signed    multiplicands
//   sub          in  1               1 subtracts the scaled product
//   fc_shift     in  1               1 scales by FC_SHIFT, 0 by RES_SHIFT
//   y            out ACC_W signed    saturated result
module sid_sat_mac
    import sid_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic signed [ACC_W:0]   acc,
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    input  logic                    sub,
    input  logic                    fc_shift,
    output logic signed [ACC_W-1:0] y
);

    localparam int PROD_W = 2 * ACC_W;
    localparam int SUM_W  = PROD_W + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] scaled;
    logic signed [SUM_W-1:0]  sum;

    always_comb begin
        prod   = PROD_W'(a) * PROD_W'(b);
        scaled = fc_shift ? (prod >>> FC_SHIFT) : (prod >>> RES_SHIFT);
        sum    = sub ? (SUM_W'(acc) - SUM_W'(scaled)) : (SUM_W'(acc) + SUM_W'(scaled));
        y      = ACC_W'(sat(64'(sum), ACC_W));
    end

endmodule

// File: rtl/sid_filter_tdm.sv
// sid_filter_tdm: time-multiplexed SID state-variable filter and mixer.
// One clk_en strobe latches the inputs and runs SUM (one voice per clock),
// HIGH, BAND, LOW, MIX and OUT; audio_out updates NUM_VOICES+5 clocks later.
// Ports:
//   clk, n_reset                 clock, asynchronous active-low reset
//   clk_en                       sample strobe
//   v                            packed unsigned voices, voice i at [i*VOICE_W +: VOICE_W]
//   reg_fc, reg_res              cutoff and resonance registers
//   reg_en, reg_mute             per-voice filter routing and direct-path mute
//   reg_hp, reg_bp, reg_lp       filter outputs added to the mix
//   reg_vol                      master volume
//   audio_out, out_valid         output sample and its one-clock update pulse
//   busy, overrun                computation in flight; sticky strobe-while-busy
module sid_filter_tdm
    import sid_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int VOICE_W    = 12,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 16
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          clk_en,
    input  logic [NUM_VOICES*VOICE_W-1:0] v,
    input  logic [10:0]                   reg_fc,
    input  logic [3:0]                    reg_res,
    input  logic [NUM_VOICES-1:0]         reg_en,
    input  logic [NUM_VOICES-1:0]         reg_mute,
    input  logic                          reg_hp,
    input  logic                          reg_bp,
    input  logic                          reg_lp,
    input  logic [3:0]                    reg_vol,
    output logic [OUT_W-1:0]              audio_out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int MIX_W = ACC_W + 3;
    localparam logic signed [MIX_W-1:0] MIX_MAX = (MIX_W'(1) <<< OUT_W) - MIX_W'(1);

    sid_filt_state_t state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0]    filt_acc_q, filt_acc_d;
    logic signed [ACC_W-1:0]    dir_acc_q, dir_acc_d;
    logic signed [ACC_W-1:0]    low_q, low_d, band_q, band_d, high_q, high_d;
    logic [OUT_W-1:0]           mix_q, mix_d;
    logic [OUT_W-1:0]           audio_out_q, audio_out_d;
    logic                       out_valid_q, out_valid_d;
    logic                       busy_q, busy_d;
    logic                       overrun_q, overrun_d;

    // Inputs captured at the strobe; data only, so they carry no reset.
    logic [NUM_VOICES*VOICE_W-1:0] v_lat_q, v_lat_d;
    logic [NUM_VOICES-1:0]         en_lat_q, en_lat_d, mute_lat_q, mute_lat_d;
    logic [11:0]                   fc_lat_q, fc_lat_d;
    logic [8:0]                    res_lat_q, res_lat_d;
    logic                          hp_lat_q, hp_lat_d, bp_lat_q, bp_lat_d, lp_lat_q, lp_lat_d;
    logic [3:0]                    vol_lat_q, vol_lat_d;

    logic [VOICE_W-1:0]         voice;
    logic signed [ACC_W-1:0]    voice_s;
    logic signed [MIX_W-1:0]    mix_sum;
    logic signed [ACC_W:0]      mac_acc;
    logic signed [ACC_W-1:0]    mac_a, mac_b, mac_y;
    logic                       mac_sub, mac_fc_shift;

    sid_sat_mac #(.ACC_W(ACC_W)) u_mac (
        .acc      (mac_acc),
        .a        (mac_a),
        .b        (mac_b),
        .sub      (mac_sub),
        .fc_shift (mac_fc_shift),
        .y        (mac_y)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        filt_acc_d   = filt_acc_q;
        dir_acc_d    = dir_acc_q;
        low_d        = low_q;
        band_d       = band_q;
        high_d       = high_q;
        mix_d        = mix_q;
        audio_out_d  = audio_out_q;
        out_valid_d  = 1'b0;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        v_lat_d      = v_lat_q;
        en_lat_d     = en_lat_q;
        mute_lat_d   = mute_lat_q;
        fc_lat_d     = fc_lat_q;
        res_lat_d    = res_lat_q;
        hp_lat_d     = hp_lat_q;
        bp_lat_d     = bp_lat_q;
        lp_lat_d     = lp_lat_q;
        vol_lat_d    = vol_lat_q;
        voice        = v_lat_q[idx_q*VOICE_W +: VOICE_W];
        voice_s      = ACC_W'(voice);
        mix_sum      = '0;
        mac_acc      = '0;
        mac_a        = '0;
        mac_b        = '0;
        mac_sub      = 1'b0;
        mac_fc_shift = 1'b0;

        // A strobe is only accepted in IDLE; any other one is flagged and dropped.
        if (clk_en && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (clk_en) begin
                    v_lat_d    = v;
                    en_lat_d   = reg_en;
                    mute_lat_d = reg_mute;
                    fc_lat_d   = 12'(reg_fc) + 12'(FC_OFFSET);
                    res_lat_d  = 9'(RES_BASE) - 9'(RES_STEP) * 9'(reg_res);
                    hp_lat_d   = reg_hp;
                    bp_lat_d   = reg_bp;
                    lp_lat_d   = reg_lp;
                    vol_lat_d  = reg_vol;
                    filt_acc_d = '0;
                    dir_acc_d  = '0;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = SUM;
                end
            end
            SUM: begin
                // Mute only applies to the direct path.
                if (en_lat_q[idx_q]) begin
                    filt_acc_d = filt_acc_q + voice_s;
                end else if (!mute_lat_q[idx_q]) begin
                    dir_acc_d = dir_acc_q + voice_s;
                end
                if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = HIGH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            HIGH: begin
                mac_acc = (ACC_W + 1)'(filt_acc_q) - (ACC_W + 1)'(low_q);
                mac_a   = band_q;
                mac_b   = ACC_W'(res_lat_q);
                mac_sub = 1'b1;
                high_d  = mac_y;
                state_d = BAND;
            end
            BAND: begin
                mac_acc      = (ACC_W + 1)'(band_q);
                mac_a        = high_q;
                mac_b        = ACC_W'(fc_lat_q);
                mac_fc_shift = 1'b1;
                band_d       = mac_y;
                state_d      = LOW;
            end
            LOW: begin
                mac_acc      = (ACC_W + 1)'(low_q);
                mac_a        = band_q;
                mac_b        = ACC_W'(fc_lat_q);
                mac_fc_shift = 1'b1;
                low_d        = mac_y;
                state_d      = MIX;
            end
            MIX: begin
                mix_sum = MIX_W'(dir_acc_q)
                        + (lp_lat_q ? MIX_W'(low_q)  : MIX_W'(0))
                        + (bp_lat_q ? MIX_W'(band_q) : MIX_W'(0))
                        + (hp_lat_q ? MIX_W'(high_q) : MIX_W'(0));
                if (mix_sum[MIX_W-1]) begin
                    mix_d = '0;
                end else if (mix_sum > MIX_MAX) begin
                    mix_d = '1;
                end else begin
                    mix_d = OUT_W'(mix_sum);
                end
                state_d = OUT;
            end
            OUT: begin
                audio_out_d = OUT_W'(((OUT_W + 4)'(mix_q) * (OUT_W + 4)'(vol_lat_q)) >> 4);
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            filt_acc_q  <= '0;
            dir_acc_q   <= '0;
            low_q       <= '0;
            band_q      <= '0;
            high_q      <= '0;
            mix_q       <= '0;
            audio_out_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            filt_acc_q  <= filt_acc_d;
            dir_acc_q   <= dir_acc_d;
            low_q       <= low_d;
            band_q      <= band_d;
            high_q      <= high_d;
            mix_q       <= mix_d;
            audio_out_q <= audio_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        v_lat_q    <= v_lat_d;
        en_lat_q   <= en_lat_d;
        mute_lat_q <= mute_lat_d;
        fc_lat_q   <= fc_lat_d;
        res_lat_q  <= res_lat_d;
        hp_lat_q   <= hp_lat_d;
        bp_lat_q   <= bp_lat_d;
        lp_lat_q   <= lp_lat_d;
        vol_lat_q  <= vol_lat_d;
    end

    assign audio_out = audio_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sid_filter_tdm.sv
// tb_sid_filter_tdm: scoreboard bench for sid_filter_tdm. Two instances share
// all inputs: the default OUT_W=16 one and an OUT_W=12 one for output clamping.
module tb_sid_filter_tdm;

    localparam int N  = 3;
    localparam int VW = 12;

    logic            clk = 1'b0;
    logic            n_reset = 1'b0;
    logic            clk_en = 1'b0;
    logic [N*VW-1:0] v = '0;
    logic [10:0]     reg_fc = '0;
    logic [3:0]      reg_res = '0;
    logic [N-1:0]    reg_en = '0;
    logic [N-1:0]    reg_mute = '0;
    logic            reg_hp = 1'b0, reg_bp = 1'b0, reg_lp = 1'b0;
    logic [3:0]      reg_vol = '0;
    logic [15:0]     audio_out;
    logic [11:0]     audio_out12;
    logic            out_valid, busy, overrun;
    logic            out_valid12, busy12, overrun12;

    always #5 clk = ~clk;

    sid_filter_tdm #(.NUM_VOICES(N), .VOICE_W(VW), .ACC_W(24), .OUT_W(16)) u_dut (
        .clk(clk), .n_reset(n_reset), .clk_en(clk_en), .v(v),
        .reg_fc(reg_fc), .reg_res(reg_res), .reg_en(reg_en), .reg_mute(reg_mute),
        .reg_hp(reg_hp), .reg_bp(reg_bp), .reg_lp(reg_lp), .reg_vol(reg_vol),
        .audio_out(audio_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    sid_filter_tdm #(.NUM_VOICES(N), .VOICE_W(VW), .ACC_W(24), .OUT_W(12)) u_dut12 (
        .clk(clk), .n_reset(n_reset), .clk_en(clk_en), .v(v),
        .reg_fc(reg_fc), .reg_res(reg_res), .reg_en(reg_en), .reg_mute(reg_mute),
        .reg_hp(reg_hp), .reg_bp(reg_bp), .reg_lp(reg_lp), .reg_vol(reg_vol),
        .audio_out(audio_out12), .out_valid(out_valid12), .busy(busy12), .overrun(overrun12)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q16[$];
    logic [11:0] exp_q12[$];
    longint m_low = 0, m_band = 0, m_high = 0;
    int out_count = 0;

    function automatic longint msat(input longint x);
        longint lim;
        lim = (64'sd1 <<< 23) - 1;
        if (x > lim) return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

    function automatic longint out_scale(input longint mix, input int w, input longint vol);
        longint m;
        m = mix;
        if (m < 0) m = 0;
        if (m > (64'sd1 <<< w) - 1) m = (64'sd1 <<< w) - 1;
        return (m * vol) >> 4;
    endfunction

    // Reference model of one sample computed from the inputs present at the strobe.
    task automatic model_sample();
        longint filt, dir, fcv, resv, mix, vi;
        filt = 0;
        dir  = 0;
        for (int i = 0; i < N; i++) begin
            vi = longint'(v[i*VW +: VW]);
            if (reg_en[i]) filt += vi;
            else if (!reg_mute[i]) dir += vi;
        end
        fcv    = longint'(reg_fc) + 64;
        resv   = 256 - 10 * longint'(reg_res);
        m_high = msat(filt - m_low - ((m_band * resv) >>> 8));
        m_band = msat(m_band + ((m_high * fcv) >>> 16));
        m_low  = msat(m_low + ((m_band * fcv) >>> 16));
        mix    = dir + (reg_lp ? m_low : 0) + (reg_bp ? m_band : 0) + (reg_hp ? m_high : 0);
        exp_q16.push_back(16'(out_scale(mix, 16, longint'(reg_vol))));
        exp_q12.push_back(12'(out_scale(mix, 12, longint'(reg_vol))));
    endtask

    task automatic model_reset();
        m_low  = 0;
        m_band = 0;
        m_high = 0;
        exp_q16.delete();
        exp_q12.delete();
    endtask

    // Output monitor: every out_valid pulse is matched against the scoreboard.
    always @(negedge clk) begin
        logic [15:0] e16;
        logic [11:0] e12;
        if (out_valid === 1'b1) begin
            out_count++;
            checks++;
            if (exp_q16.size() == 0) begin
                errors++;
                $display("FAIL out16_unexpected: out_valid with nothing pending, audio_out=%0d", audio_out);
            end else begin
                e16 = exp_q16.pop_front();
                if (audio_out !== e16) begin
                    errors++;
                    $display("FAIL out16_sample: audio_out=%0d expected %0d", audio_out, e16);
                end
            end
        end
        if (out_valid12 === 1'b1) begin
            checks++;
            if (exp_q12.size() == 0) begin
                errors++;
                $display("FAIL out12_unexpected: out_valid with nothing pending, audio_out=%0d", audio_out12);
            end else begin
                e12 = exp_q12.pop_front();
                if (audio_out12 !== e12) begin
                    errors++;
                    $display("FAIL out12_sample: audio_out=%0d expected %0d", audio_out12, e12);
                end
            end
        end
    end

    task automatic set_regs(input logic [N*VW-1:0] vv, input logic [N-1:0] en, input logic [N-1:0] mute,
                            input logic hp, input logic bp, input logic lp,
                            input logic [10:0] fc, input logic [3:0] res, input logic [3:0] vol);
        v = vv; reg_en = en; reg_mute = mute;
        reg_hp = hp; reg_bp = bp; reg_lp = lp;
        reg_fc = fc; reg_res = res; reg_vol = vol;
    endtask

    task automatic strobe();
        @(negedge clk);
        clk_en = 1'b1;
        model_sample();
        @(negedge clk);
        clk_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q16.size() != 0 || exp_q12.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_q16.size() != 0 || exp_q12.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d samples pending after %0d cycles, expected 0",
                     exp_q16.size(), exp_q12.size(), n);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clk_en  = 1'b0;
        n_reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        int lat;
        n_reset = 1'b0;
        model_reset();
        repeat (5) begin
            @(negedge clk);
            v = N*VW'({$urandom(), $urandom()});
            reg_fc = 11'($urandom()); reg_res = 4'($urandom()); reg_vol = 4'($urandom());
            reg_en = N'($urandom()); reg_mute = N'($urandom());
            reg_hp = 1'($urandom()); reg_bp = 1'($urandom()); reg_lp = 1'($urandom());
            clk_en = 1'($urandom());
        end
        checks++;
        if (audio_out !== 16'd0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: audio_out=%0d out_valid=%b busy=%b overrun=%b, expected all 0",
                     audio_out, out_valid, busy, overrun);
        end
        checks++;
        if (audio_out12 !== 12'd0 || out_valid12 !== 1'b0 || busy12 !== 1'b0 || overrun12 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state12: audio_out=%0d out_valid=%b busy=%b overrun=%b, expected all 0",
                     audio_out12, out_valid12, busy12, overrun12);
        end
        clk_en = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        clk_en = 1'b1;
        model_sample();
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: busy=%b after strobe edge, expected 1", busy);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL latency: out_valid after %0d clocks, expected 8", lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: busy=%b with out_valid, expected 0", busy);
        end
        drain();
    endtask

    task automatic test_direct();
        set_regs({12'd3000, 12'd2000, 12'd1000}, 3'b000, 3'b000, 0, 0, 0, 11'd0, 4'd0, 4'd15);
        strobe();
        drain();
        checks++;
        if (audio_out !== 16'd5625) begin
            errors++;
            $display("FAIL direct_sum: audio_out=%0d expected 5625", audio_out);
        end
        reg_vol = 4'd8;
        strobe();
        drain();
        checks++;
        if (audio_out !== 16'd3000) begin
            errors++;
            $display("FAIL direct_vol8: audio_out=%0d expected 3000", audio_out);
        end
    endtask

    task automatic test_mute_routing();
        set_regs({12'd3000, 12'd2000, 12'd1000}, 3'b000, 3'b100, 0, 0, 0, 11'd0, 4'd0, 4'd15);
        strobe();
        drain();
        checks++;
        if (audio_out !== 16'd2812) begin
            errors++;
            $display("FAIL mute_v2: audio_out=%0d expected 2812", audio_out);
        end
        reg_en = 3'b100;
        strobe();
        drain();
        checks++;
        if (audio_out !== 16'd2812) begin
            errors++;
            $display("FAIL filter_routed_no_mode: audio_out=%0d expected 2812", audio_out);
        end
    endtask

    task automatic test_lowpass_dc();
        pulse_reset();
        set_regs({12'd0, 12'd0, 12'd4000}, 3'b001, 3'b000, 0, 0, 1, 11'd2047, 4'd0, 4'd15);
        repeat (400) begin
            strobe();
            drain();
        end
        checks++;
        if (audio_out < 16'd3686 || audio_out > 16'd3814) begin
            errors++;
            $display("FAIL lowpass_settle: audio_out=%0d expected near 3750", audio_out);
        end
    endtask

    task automatic test_clamp();
        set_regs({12'd4095, 12'd4095, 12'd4095}, 3'b000, 3'b000, 0, 0, 0, 11'd0, 4'd0, 4'd15);
        strobe();
        drain();
        checks++;
        if (audio_out12 !== 12'd3839) begin
            errors++;
            $display("FAIL clamp_high12: audio_out=%0d expected 3839", audio_out12);
        end
        checks++;
        if (audio_out !== 16'd11517) begin
            errors++;
            $display("FAIL noclamp16: audio_out=%0d expected 11517", audio_out);
        end
        pulse_reset();
        set_regs({12'd0, 12'd0, 12'd4000}, 3'b001, 3'b000, 1, 0, 0, 11'd2047, 4'd0, 4'd15);
        repeat (150) begin
            strobe();
            drain();
        end
        v = {12'd0, 12'd0, 12'd0};
        strobe();
        drain();
        checks++;
        if (audio_out !== 16'd0 || audio_out12 !== 12'd0) begin
            errors++;
            $display("FAIL clamp_low: audio_out=%0d/%0d expected 0/0", audio_out, audio_out12);
        end
    endtask

    task automatic test_overrun();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_idle: overrun=%b expected 0", overrun);
        end
        set_regs({12'd300, 12'd200, 12'd100}, 3'b000, 3'b000, 0, 0, 0, 11'd0, 4'd0, 4'd15);
        strobe();
        repeat (2) @(negedge clk);
        clk_en = 1'b1;
        set_regs({12'd4000, 12'd4000, 12'd4000}, 3'b000, 3'b000, 0, 0, 0, 11'd5, 4'd3, 4'd1);
        @(negedge clk);
        clk_en = 1'b0;
        checks++;
        if (overrun !== 1'b1 || overrun12 !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b/%b expected 1/1", overrun, overrun12);
        end
        drain();
        checks++;
        if (audio_out !== 16'd562) begin
            errors++;
            $display("FAIL overrun_result: audio_out=%0d expected 562", audio_out);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: overrun=%b expected 1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        set_regs({12'd3000, 12'd2000, 12'd1000}, 3'b000, 3'b000, 0, 0, 0, 11'd0, 4'd0, 4'd15);
        strobe();
        @(posedge clk);
        @(negedge clk);
        n_reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (audio_out !== 16'd0 || busy !== 1'b0 || overrun !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: audio_out=%0d busy=%b overrun=%b out_valid=%b expected all 0",
                     audio_out, busy, overrun, out_valid);
        end
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        seen = out_count;
        repeat (15) @(negedge clk);
        checks++;
        if (out_count != seen) begin
            errors++;
            $display("FAIL reset_mid_no_valid: %0d out_valid pulses after reset, expected 0", out_count - seen);
        end
        strobe();
        drain();
        checks++;
        if (audio_out !== 16'd5625) begin
            errors++;
            $display("FAIL after_reset_sample: audio_out=%0d expected 5625", audio_out);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_direct();
        test_mute_routing();
        test_lowpass_dc();
        test_clamp();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
